// File: rtl/cpu_int_pkg.sv
// cpu_int_pkg: shared types and constants for the interrupt/reset sequencer.
package cpu_int_pkg;
   typedef enum logic [2:0] {
      RST_WAIT, RST_STK, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI
   } state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;
   localparam logic [1:0] PSEL_NONE = 2'd0;
   localparam logic [1:0] PSEL_PCH  = 2'd1;
   localparam logic [1:0] PSEL_PCL  = 2'd2;
   localparam logic [1:0] PSEL_P    = 2'd3;
   localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
   localparam logic [15:0] DEF_RES_VEC = 16'hFFFC;
   localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;
endpackage

// File: rtl/nmi_edge_det.sv
// nmi_edge_det: falling-edge detector on nmi_n with a sticky pending flag.
module nmi_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic nmi_n,
   input  logic clr,
   output logic pend
);
   logic hist;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hist <= 1'b1;
         pend <= 1'b0;
      end else begin
         hist <= nmi_n;
         pend <= (hist & ~nmi_n) | (pend & ~clr);
      end
endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: reset/NMI/IRQ/BRK sequencer that pushes PC and P, then loads the vector.
module int_sequencer
   import cpu_int_pkg::*;
#(
   parameter logic [15:0] NMI_VEC = DEF_NMI_VEC,
   parameter logic [15:0] RES_VEC = DEF_RES_VEC,
   parameter logic [15:0] IRQ_VEC = DEF_IRQ_VEC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        i_flag,
   input  logic        brk,
   input  logic        instr_boundary,
   input  logic [7:0]  sp,
   output logic        seq_active,
   output logic [15:0] addr,
   output logic [1:0]  push_sel,
   output logic        write_en,
   output logic        sp_dec,
   output logic        pcl_load,
   output logic        pch_load,
   output logic        set_i,
   output logic        b_flag,
   output logic        done
);
   state_t      state, state_nx;
   src_t        src, src_nx;
   logic [1:0]  cnt;
   logic        nmi_pend, irq_ok, start, hijack, stk, push;
   logic [15:0] vec;
   assign irq_ok = ~irq_n & ~i_flag;
   assign start  = (state == IDLE) & instr_boundary & (nmi_pend | irq_ok | brk);
   // a pending NMI at the last push takes over the vector and is consumed
   assign hijack = (state == PUSH_P) & nmi_pend;
   nmi_edge_det u_nmi (
      .clk(clk),
      .reset(reset),
      .nmi_n(nmi_n),
      .clr(hijack),
      .pend(nmi_pend)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RST_WAIT;
         src   <= SRC_NONE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nx;
         src   <= src_nx;
         cnt   <= (state == RST_STK) ? cnt + 2'd1 : 2'd0;
      end
   always_comb begin
      state_nx = state;
      src_nx   = src;
      case (state)
         RST_WAIT: state_nx = RST_STK;
         RST_STK:  state_nx = (cnt == 2'd2) ? VEC_LO : RST_STK;
         IDLE: if (start) begin
            state_nx = PUSH_PCH;
            src_nx   = nmi_pend ? SRC_NMI : irq_ok ? SRC_IRQ : SRC_BRK;
         end
         PUSH_PCH: state_nx = PUSH_PCL;
         PUSH_PCL: state_nx = PUSH_P;
         PUSH_P: begin
            state_nx = VEC_LO;
            src_nx   = hijack ? SRC_NMI : src;
         end
         VEC_LO: state_nx = VEC_HI;
         VEC_HI: begin
            state_nx = IDLE;
            src_nx   = SRC_NONE;
         end
         default: state_nx = RST_WAIT;
      endcase
   end
   assign vec  = (src == SRC_NMI) ? NMI_VEC : (src == SRC_NONE) ? RES_VEC : IRQ_VEC;
   assign push = state inside {PUSH_PCH, PUSH_PCL, PUSH_P};
   assign stk  = push | (state == RST_STK);
   assign seq_active = state != IDLE;
   assign addr = stk ? {8'h01, sp} : (state == VEC_LO) ? vec : (state == VEC_HI) ? vec + 16'd1 : 16'd0;
   assign push_sel = (state == PUSH_PCH) ? PSEL_PCH : (state == PUSH_PCL) ? PSEL_PCL :
                     (state == PUSH_P) ? PSEL_P : PSEL_NONE;
   assign write_en = push;
   assign sp_dec   = stk;
   assign pcl_load = state == VEC_LO;
   assign set_i    = state == VEC_LO;
   assign pch_load = state == VEC_HI;
   assign done     = state == VEC_HI;
   assign b_flag   = (state == PUSH_P) & (src == SRC_BRK);
endmodule
